// File: rtl/prbs_lane_checker.sv
// prbs_lane_checker: N-lane self-synchronising PRBS7/15/31 checker.
// Each lane checks W-bit words against the selected polynomial, tracks lock
// with a HUNT/SYNC hysteresis FSM and keeps a saturating error counter.
// Optional build macro PRBS_CHK_ERRBIT_CNT_EN: the error counter adds the
// number of mismatched bits of each errored word instead of 1.
module prbs_lane_checker #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int SYNC_GOOD = 4,
    parameter int LOSS_BAD  = 3,
    parameter int CNT_W     = 16
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic [1:0]         I_mode,
    input  logic               I_cnt_clr,
    input  logic [N-1:0]       I_valid,
    input  logic [N*W-1:0]     I_data,
    output logic [N-1:0]       O_sync_state,
    output logic [N-1:0]       O_chk_edge,
    output logic [N-1:0]       O_chk_result,
    output logic [N*CNT_W-1:0] O_err_cnt
);
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_SYNC = 1'b1;
    localparam int RUN_MAX = (SYNC_GOOD > LOSS_BAD) ? SYNC_GOOD : LOSS_BAD;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int POP_W   = $clog2(W + 1);
    localparam int SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] mode_reg;
    logic       mode_chg;

    // Remember last cycle's mode so a change can resynchronise every lane.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) mode_reg <= 2'd0;
        else          mode_reg <= I_mode;
    end

    assign mode_chg = (I_mode != mode_reg);

    genvar gi, bi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [30:0]      hist_reg;
            logic [0:0]       state_reg;
            logic [RUN_W-1:0] run_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             edge_reg;
            logic             result_reg;
            logic [W+30:0]    ext;
            logic [W-1:0]     mis7, mis15, mis31, mis;
            logic [30:0]      zmask;
            logic             zero_run;
            logic             errored;
            logic [POP_W-1:0] inc;
            logic [SUM_W-1:0] cnt_sum;
            logic [CNT_W-1:0] cnt_next;

            // Word on top of the history: ext[31+i] is word bit i, ext[30] is
            // the most recent earlier bit, so in-word references just work.
            assign ext = {I_data[gi*W +: W], hist_reg};

            for (bi = 0; bi < W; bi++) begin : g_bit
                assign mis7[bi]  = ext[31+bi] ^ ext[31+bi-7]  ^ ext[31+bi-6];
                assign mis15[bi] = ext[31+bi] ^ ext[31+bi-15] ^ ext[31+bi-14];
                assign mis31[bi] = ext[31+bi] ^ ext[31+bi-31] ^ ext[31+bi-28];
            end

            // Select mismatch vector and zero-run window (top L bits of the new history).
            always_comb begin
                mis   = mis31;
                zmask = 31'h7FFF_FFFF;
                case (I_mode)
                    2'd0: begin mis = mis7;  zmask = 31'h7F00_0000; end
                    2'd1: begin mis = mis15; zmask = 31'h7FFF_0000; end
                    default: begin mis = mis31; zmask = 31'h7FFF_FFFF; end
                endcase
            end

            assign zero_run = ((ext[W+30:W] & zmask) == 31'd0);
            assign errored  = (|mis) | zero_run;

`ifdef PRBS_CHK_ERRBIT_CNT_EN
            // Popcount of mismatched bits; a zero-run-only error still adds one.
            always_comb begin
                inc = '0;
                for (int i = 0; i < W; i++) inc = inc + POP_W'(mis[i]);
                if (mis == '0) inc = POP_W'(1);
            end
`else
            // One count per errored word.
            always_comb begin
                inc = POP_W'(1);
            end
`endif

            assign cnt_sum  = SUM_W'(cnt_reg) + SUM_W'(inc);
            assign cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

            // Per-lane history, sync FSM, result strobe and error counter.
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    hist_reg   <= '0;
                    state_reg  <= ST_HUNT;
                    run_reg    <= '0;
                    cnt_reg    <= '0;
                    edge_reg   <= 1'b0;
                    result_reg <= 1'b0;
                end else begin
                    edge_reg   <= I_valid[gi] & ~mode_chg;
                    result_reg <= I_valid[gi] & ~mode_chg & ~errored;
                    if (mode_chg) begin
                        state_reg <= ST_HUNT;
                        run_reg   <= '0;
                    end else if (I_valid[gi]) begin
                        hist_reg <= ext[W+30:W];
                        case (state_reg)
                            ST_HUNT: begin
                                if (errored) begin
                                    run_reg <= '0;
                                end else if (run_reg >= RUN_W'(SYNC_GOOD - 1)) begin
                                    state_reg <= ST_SYNC;
                                    run_reg   <= '0;
                                end else begin
                                    run_reg <= run_reg + RUN_W'(1);
                                end
                            end
                            default: begin
                                if (!errored) begin
                                    run_reg <= '0;
                                end else if (run_reg >= RUN_W'(LOSS_BAD - 1)) begin
                                    state_reg <= ST_HUNT;
                                    run_reg   <= '0;
                                end else begin
                                    run_reg <= run_reg + RUN_W'(1);
                                end
                            end
                        endcase
                    end
                    if (I_cnt_clr)
                        cnt_reg <= '0;
                    else if (!mode_chg && I_valid[gi] && state_reg == ST_SYNC && errored)
                        cnt_reg <= cnt_next;
                end
            end

            assign O_sync_state[gi]            = state_reg[0];
            assign O_chk_edge[gi]              = edge_reg;
            assign O_chk_result[gi]            = result_reg;
            assign O_err_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
endmodule

// File: tb/tb_prbs_lane_checker.sv
// Testbench for prbs_lane_checker: N=2, W=16, PRBS15 start, scoreboard-checked
// against a bit-stream reference model, plus directed checks at key points.
module tb_prbs_lane_checker;
    localparam int N    = 2;
    localparam int W    = 16;
    localparam int SG   = 4;
    localparam int LB   = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam int MAXB = 8192;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     mode = 2'd1;
    logic           cnt_clr = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [N*W-1:0] data = '0;
    logic [N-1:0]   sync_state, chk_edge, chk_result;
    logic [N*CW-1:0] err_cnt;

    prbs_lane_checker #(.N(N), .W(W), .SYNC_GOOD(SG), .LOSS_BAD(LB), .CNT_W(CW)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_mode(mode), .I_cnt_clr(cnt_clr),
        .I_valid(valid), .I_data(data), .O_sync_state(sync_state),
        .O_chk_edge(chk_edge), .O_chk_result(chk_result), .O_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct { int lane; int result; int sync; int cnt; } exp_t;
    exp_t sb[$];

    // reference model: full received bit stream per lane plus lock bookkeeping
    bit rx [N][0:MAXB-1];
    int rx_n [N];
    bit gb [N][0:MAXB-1];
    int gn [N];
    int m_state [N];
    int m_run [N];
    int m_cnt [N];
    int m_prev_mode = 0;
    int cur_mode = 1;
    bit lane1_on = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, expv);
        end
    endtask

    function automatic int tap_l(input int m);
        return (m == 0) ? 7 : (m == 1) ? 15 : 31;
    endfunction

    function automatic int tap_t(input int m);
        return (m == 0) ? 6 : (m == 1) ? 14 : 28;
    endfunction

    function automatic bit rx_at(input int k, input int idx);
        return (idx < 0) ? 1'b0 : rx[k][idx];
    endfunction

    function automatic bit gb_at(input int k, input int idx);
        return (idx < 0) ? 1'b0 : gb[k][idx];
    endfunction

    // Clean PRBS source per lane, continuing its own stream under the current mode.
    function automatic logic [W-1:0] gen_word(input int k);
        logic [W-1:0] w;
        int n;
        int l = tap_l(cur_mode);
        int t = tap_t(cur_mode);
        w = '0;
        for (int i = 0; i < W; i++) begin
            n = gn[k] % MAXB;
            if (gn[k] < 15) gb[k][n] = (gn[k] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            else            gb[k][n] = gb_at(k, n - l) ^ gb_at(k, n - t);
            w[i] = gb[k][n];
            gn[k] = gn[k] + 1;
        end
        return w;
    endfunction

    // Predict the checker response to one received word and queue it.
    task automatic model_word(input int k, input logic [W-1:0] word, input bit clr);
        int l, t, nb, mism, add;
        bit zr, err;
        exp_t e;
        l = tap_l(cur_mode);
        t = tap_t(cur_mode);
        nb = rx_n[k];
        for (int i = 0; i < W; i++) rx[k][nb + i] = word[i];
        rx_n[k] = nb + W;
        mism = 0;
        for (int i = 0; i < W; i++)
            if ((rx_at(k, nb + i - l) ^ rx_at(k, nb + i - t)) != word[i]) mism++;
        zr = 1'b1;
        for (int j = nb + W - l; j < nb + W; j++) if (rx_at(k, j)) zr = 1'b0;
        err = (mism != 0) || zr;
        if (m_state[k] == 1 && err) begin
`ifdef PRBS_CHK_ERRBIT_CNT_EN
            add = (mism != 0) ? mism : 1;
`else
            add = 1;
`endif
            m_cnt[k] = (m_cnt[k] + add > CMAX) ? CMAX : m_cnt[k] + add;
        end
        if (clr) m_cnt[k] = 0;
        if (m_state[k] == 0) begin
            if (err) m_run[k] = 0;
            else begin
                m_run[k]++;
                if (m_run[k] == SG) begin m_state[k] = 1; m_run[k] = 0; end
            end
        end else begin
            if (!err) m_run[k] = 0;
            else begin
                m_run[k]++;
                if (m_run[k] == LB) begin m_state[k] = 0; m_run[k] = 0; end
            end
        end
        e.lane = k; e.result = err ? 0 : 1; e.sync = m_state[k]; e.cnt = m_cnt[k];
        sb.push_back(e);
    endtask

    // One clock of stimulus, driven on the falling edge; lane 1 runs random traffic when enabled.
    task automatic step(input bit v0, input logic [W-1:0] d0, input bit clr);
        bit chg, v1;
        logic [W-1:0] d1;
        int p;
        @(negedge clk);
        chg = (cur_mode != m_prev_mode);
        m_prev_mode = cur_mode;
        v1 = 1'b0;
        d1 = '0;
        if (lane1_on && !chg && $urandom_range(0, 1) == 1) begin
            v1 = 1'b1;
            d1 = gen_word(1);
            if ($urandom_range(0, 7) == 0) begin
                p = $urandom_range(0, W - 1);
                d1[p] = ~d1[p];
            end
        end
        mode = 2'(cur_mode);
        cnt_clr = clr;
        valid = {v1, v0};
        data = {d1, d0};
        if (chg) begin
            for (int k = 0; k < N; k++) begin m_state[k] = 0; m_run[k] = 0; end
        end else begin
            if (v0) model_word(0, d0, clr);
            if (v1) model_word(1, d1, clr);
        end
        if (clr) for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0);
    endtask

    task automatic good0();
        step(1'b1, gen_word(0), 1'b0);
    endtask

    task automatic flip0(input bit clr);
        logic [W-1:0] d;
        d = gen_word(0);
        d[0] = ~d[0];
        step(1'b1, d, clr);
    endtask

    // Monitor: every checked word pops and compares one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (chk_edge[k]) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_edge lane %0d: edge=1 with no word outstanding", k);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_lane", k, e.lane);
                        chk("sb_result", int'(chk_result[k]), e.result);
                        chk("sb_sync", int'(sync_state[k]), e.sync);
                        chk("sb_cnt", int'(err_cnt[k*CW +: CW]), e.cnt);
                        $display("lane %0d word: result=%0d sync=%0d cnt=%0d", k,
                                 chk_result[k], sync_state[k], err_cnt[k*CW +: CW]);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        sb.delete();
        m_prev_mode = 0;
        for (int k = 0; k < N; k++) begin
            rx_n[k] = 0; m_state[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) gn[k] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();

        // Clean PRBS15 on lane 0 from reset: word 1 fails, lock on word 5.
        for (int w = 1; w <= 5; w++) begin
            good0();
            if (w == 2) begin
                chk("t2_w1_edge", int'(chk_edge[0]), 1);
                chk("t2_w1_result", int'(chk_result[0]), 0);
            end
            if (w == 5) chk("t2_w4_sync", int'(sync_state[0]), 0);
        end
        idle();
        chk("t2_w5_sync", int'(sync_state[0]), 1);
        chk("t2_w5_result", int'(chk_result[0]), 1);
        chk("t2_lane1_idle", int'(sync_state[1]), 0);

        // Single flipped bit in SYNC.
        lane1_on = 1'b1;
        repeat (3) good0();
        flip0(1'b0);
        good0();
        chk("t3_flip_result", int'(chk_result[0]), 0);
`ifdef PRBS_CHK_ERRBIT_CNT_EN
        chk("t3_flip_cnt", int'(err_cnt[CW-1:0]), 3);
`else
        chk("t3_flip_cnt", int'(err_cnt[CW-1:0]), 1);
`endif
        idle();
        chk("t3_next_result", int'(chk_result[0]), 1);
        chk("t3_sync_kept", int'(sync_state[0]), 1);

        // Three all-zero words: zero-run guard drops sync on the third.
        step(1'b0, '0, 1'b1);
        repeat (3) step(1'b1, '0, 1'b0);
        idle();
        chk("t4_sync_lost", int'(sync_state[0]), 0);
`ifndef PRBS_CHK_ERRBIT_CNT_EN
        chk("t4_cnt", int'(err_cnt[CW-1:0]), 3);
`endif
        repeat (6) good0();

        // Repeated loss and re-lock until the counter saturates, then clear on an error.
        step(1'b0, '0, 1'b1);
        for (int r = 0; r < 7; r++) begin
            repeat (3) flip0(1'b0);
            repeat (4) good0();
        end
        idle();
        chk("t5_saturated", int'(err_cnt[CW-1:0]), CMAX);
        flip0(1'b1);
        idle();
        chk("t5_clr_wins", int'(err_cnt[CW-1:0]), 0);

        // Reset mid-stream: outputs clear without a clock edge.
        repeat (2) good0();
        chk("t1_pre_reset_sync", int'(sync_state[0]), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        valid = '0;
        cnt_clr = 1'b0;
        model_reset();
        #1;
        chk("t1_rst_sync", int'(sync_state), 0);
        chk("t1_rst_edge", int'(chk_edge), 0);
        chk("t1_rst_result", int'(chk_result), 0);
        chk("t1_rst_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        good0();
        idle();
        chk("t1_first_edge", int'(chk_edge[0]), 1);
        chk("t1_first_result", int'(chk_result[0]), 0);

        // Mode switch PRBS15 -> PRBS31 while locked.
        repeat (5) good0();
        lane1_on = 1'b0;
        idle();
        chk("t6_locked", int'(sync_state[0]), 1);
        cur_mode = 2;
        idle();
        idle();
        chk("t6_hunt", int'(sync_state), 0);
        chk("t6_no_edge", int'(chk_edge), 0);
        chk("t6_cnt0_kept", int'(err_cnt[CW-1:0]), m_cnt[0]);
        chk("t6_cnt1_kept", int'(err_cnt[2*CW-1:CW]), m_cnt[1]);
        repeat (4) good0();
        idle();
        chk("t6_relock", int'(sync_state[0]), 1);

        // Random tail on both lanes, including a switch to PRBS7.
        lane1_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 30) begin
                cur_mode = 0;
                idle();
            end else if ($urandom_range(0, 3) == 0) begin
                idle();
            end else if ($urandom_range(0, 5) == 0) begin
                flip0(1'($urandom_range(0, 9) == 0));
            end else begin
                good0();
            end
        end
        lane1_on = 1'b0;
        repeat (3) idle();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
